// File: rtl/vcmux_rr.sv
// Round-robin virtual-channel output multiplexer with packet-level grant
// holding and a hold-length limiter that forces hand-over under contention.
module vcmux_rr #(
    parameter int NUM_VC   = 4,
    parameter int DATA_W   = 64,
    parameter int VCH_W    = 2,
    parameter int PORT_W   = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_VC-1:0]          ovalid_in,
    input  logic [NUM_VC*DATA_W-1:0]   odata_in,
    input  logic [NUM_VC*VCH_W-1:0]    ovch_in,
    input  logic [NUM_VC-1:0]          req_in,
    input  logic [NUM_VC*PORT_W-1:0]   port_in,
    output logic                       ovalid,
    output logic [DATA_W-1:0]          odata,
    output logic [VCH_W-1:0]           ovch,
    output logic                       req,
    output logic [PORT_W-1:0]          port,
    output logic [NUM_VC-1:0]          vcsel,
    output logic                       preempt
);

    localparam int PTR_W = $clog2(NUM_VC);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_VC - 1);

    logic [NUM_VC-1:0] last_q;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_VC-1:0] hold, cand, rr_gnt, grt;
    logic              anyhold, others, frc, found;
    logic [PTR_W-1:0]  idx, grt_idx, last_idx;

    function automatic logic [PTR_W-1:0] enc(input logic [NUM_VC-1:0] v);
        enc = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (v[i]) enc = PTR_W'(i);
        end
    endfunction

    always_comb begin
        hold    = last_q & req_in;
        anyhold = |hold;
        others  = |(req_in & ~last_q);
        frc     = (MAX_HOLD != 0) && anyhold && others
                  && (cnt_q == HOLD_MAX);
    end

    // Under force the owner is masked so the search lands on a competitor.
    always_comb begin
        cand   = frc ? (req_in & ~last_q) : req_in;
        rr_gnt = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_VC);
            if (!found && cand[idx]) begin
                found       = 1'b1;
                rr_gnt[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        grt      = (anyhold && !frc) ? hold : rr_gnt;
        grt_idx  = enc(grt);
        last_idx = enc(last_q);
        ptr_d    = (grt != '0) ? grt_idx : ptr_q;
        cnt_d    = cnt_q;
        if ((grt == '0) || (grt != last_q)) begin
            cnt_d = '0;
        end else if (others && (cnt_q != HOLD_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            last_q <= '0;
            ptr_q  <= PTR_RST;
            cnt_q  <= '0;
        end else begin
            last_q <= grt;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        vcsel   = grt;
        preempt = frc;
        req     = |req_in;
        port    = '0;
        if (grt != '0) port = port_in[grt_idx*PORT_W +: PORT_W];
        ovalid  = |(last_q & ovalid_in);
        odata   = '0;
        ovch    = '0;
        if (last_q != '0) begin
            odata = odata_in[last_idx*DATA_W +: DATA_W];
            ovch  = ovch_in[last_idx*VCH_W +: VCH_W];
        end
    end

endmodule

// File: tb/tb_vcmux_rr.sv
// Directed bench for vcmux_rr: two instances (unlimited hold, MAX_HOLD=4)
// share stimulus; data-path expectations flow through a one-cycle queue.
module tb_vcmux_rr;

    typedef struct {
        int          d;
        logic        v;
        logic [63:0] data;
        logic [1:0]  vch;
    } exp_t;

    logic         clk;
    logic         rst_;
    logic [3:0]   ovalid_in;
    logic [255:0] odata_in;
    logic [7:0]   ovch_in;
    logic [3:0]   req_in;
    logic [11:0]  port_in;

    logic         ovalid_o  [2];
    logic [63:0]  odata_o   [2];
    logic [1:0]   ovch_o    [2];
    logic         req_o     [2];
    logic [2:0]   port_o    [2];
    logic [3:0]   vcsel_o   [2];
    logic         preempt_o [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vcmux_rr #(
            .NUM_VC(4), .DATA_W(64), .VCH_W(2),
            .PORT_W(3), .MAX_HOLD(g * 4)
        ) u_dut (
            .clk       (clk),
            .rst_      (rst_),
            .ovalid_in (ovalid_in),
            .odata_in  (odata_in),
            .ovch_in   (ovch_in),
            .req_in    (req_in),
            .port_in   (port_in),
            .ovalid    (ovalid_o[g]),
            .odata     (odata_o[g]),
            .ovch      (ovch_o[g]),
            .req       (req_o[g]),
            .port      (port_o[g]),
            .vcsel     (vcsel_o[g]),
            .preempt   (preempt_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dat(input int i);
        dat = 64'h1111_1111_1111_1111 * 64'(i + 1);
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        oh2i = 0;
        for (int i = 0; i < 4; i++) if (v[i]) oh2i = i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int d, input logic r_rst,
                        input logic [3:0] r, input logic [3:0] es,
                        input logic ep, input string tag);
        exp_t        e;
        logic [2:0]  pexp;
        rst_   = r_rst;
        req_in = r;
        #1;
        pexp = (es == 4'b0) ? 3'd0 : 3'(7 - oh2i(es));
        chk({tag, ".vcsel"},   vcsel_o[d],   es);
        chk({tag, ".port"},    port_o[d],    pexp);
        chk({tag, ".preempt"}, preempt_o[d], ep);
        chk({tag, ".req"},     req_o[d],     |r);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb: got empty queue expected entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".ovalid"}, ovalid_o[e.d], e.v);
            chk({tag, ".odata"},  odata_o[e.d],  e.data);
            chk({tag, ".ovch"},   ovch_o[e.d],   e.vch);
        end
        e.d = d;
        if (r_rst || es == 4'b0) begin
            e.v = 1'b0; e.data = '0; e.vch = '0;
        end else begin
            e.v = 1'b1; e.data = dat(oh2i(es)); e.vch = 2'(oh2i(es));
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t z;
        ovalid_in = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            odata_in[i*64 +: 64] = dat(i);
            ovch_in[i*2 +: 2]    = 2'(i);
            port_in[i*3 +: 3]    = 3'(7 - i);
        end
        rst_   = 1'b1;
        req_in = 4'b0;
        @(posedge clk);
        #1;
        z.d = 0; z.v = 1'b0; z.data = '0; z.vch = '0;
        sbq.push_back(z);

        for (int k = 0; k < 4; k++)
            step(0, 1'b0, 4'b0110, 4'b0010, 1'b0, "two_req");

        step(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "rst_rr");
        step(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "rr0");
        step(0, 1'b0, 4'b1110, 4'b0010, 1'b0, "rr1");
        step(0, 1'b0, 4'b1101, 4'b0100, 1'b0, "rr2");
        step(0, 1'b0, 4'b1011, 4'b1000, 1'b0, "rr3");
        step(0, 1'b0, 4'b0111, 4'b0001, 1'b0, "rr_wrap");
        step(0, 1'b0, 4'b1110, 4'b0010, 1'b0, "rr_next");

        step(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "rst_hold");
        step(0, 1'b0, 4'b0100, 4'b0100, 1'b0, "hold_start");
        for (int k = 0; k < 4; k++)
            step(0, 1'b0, 4'b0101, 4'b0100, 1'b0, "hold_keep");
        step(0, 1'b0, 4'b0001, 4'b0001, 1'b0, "hold_release");

        step(1, 1'b1, 4'b0000, 4'b0000, 1'b0, "rst_force");
        step(1, 1'b0, 4'b0010, 4'b0010, 1'b0, "force_own0");
        step(1, 1'b0, 4'b0010, 4'b0010, 1'b0, "force_own1");
        for (int k = 0; k < 4; k++)
            step(1, 1'b0, 4'b1010, 4'b0010, 1'b0, "force_wait");
        step(1, 1'b0, 4'b1010, 4'b1000, 1'b1, "force_fire");
        step(1, 1'b0, 4'b1010, 4'b1000, 1'b0, "force_after");
        step(1, 1'b0, 4'b0010, 4'b0010, 1'b0, "force_regain");

        step(1, 1'b0, 4'b0000, 4'b0000, 1'b0, "idle0");
        step(1, 1'b0, 4'b0000, 4'b0000, 1'b0, "idle1");
        chk("idle.hold_cnt", g_dut[1].u_dut.cnt_q, 64'd0);

        step(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "rst_mid");
        step(0, 1'b0, 4'b1000, 4'b1000, 1'b0, "mid_own0");
        step(0, 1'b0, 4'b1000, 4'b1000, 1'b0, "mid_own1");
        step(0, 1'b1, 4'b1000, 4'b1000, 1'b0, "mid_rst");
        chk("mid_rst.last", g_dut[0].u_dut.last_q, 64'd0);
        step(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "post_rst0");
        step(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "post_rst1");
        step(0, 1'b0, 4'b0000, 4'b0000, 1'b0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
